// File: rtl/clock_set_ctrl.sv
// Mode/set-sequence controller for a cascaded 60/60/24 clock: button debounce,
// RUN/SET state machine, per-stage set selects, 1 Hz tick and set-mode blink.

module clock_set_ctrl_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1, sync2, level, level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            rise    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            rise    <= level & ~level_q;
            // level only flips after DEB_CYCLES consecutive disagreeing samples
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module clock_set_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int DEB_CYCLES = 500000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    output logic       ENABLE,
    output logic [1:0] SEL_SEC,
    output logic [1:0] SEL_MIN,
    output logic [1:0] SEL_HOUR,
    output logic       INC_MODE,
    output logic [1:0] MODE_STATE,
    output logic       BLINK
);
    localparam int NUM_BTN = 2;
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        presc;
    logic [BW-1:0]        bcnt;
    logic                 phase;
    logic [NUM_BTN-1:0]   btn, btn_rise;
    logic                 mode_rise, inc_rise;

    assign btn       = {BTN_INC, BTN_MODE};
    assign mode_rise = btn_rise[0];
    assign inc_rise  = btn_rise[1];
    assign state_nxt = state_t'(state + 2'd1);
    assign MODE_STATE = state;

    clock_set_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .raw     (btn),
        .rise    (btn_rise)
    );

    // {SEL_HOUR, SEL_MIN, SEL_SEC}
    function automatic logic [5:0] sel_enc(state_t s);
        case (s)
            RUN:      sel_enc = 6'b01_01_01;
            SET_HOUR: sel_enc = 6'b10_00_00;
            SET_MIN:  sel_enc = 6'b00_10_00;
            default:  sel_enc = 6'b00_00_10;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state                       <= RUN;
            {SEL_HOUR, SEL_MIN, SEL_SEC} <= 6'b01_01_01;
            ENABLE                      <= 1'b0;
            INC_MODE                    <= 1'b0;
            BLINK                       <= 1'b0;
            presc                       <= '0;
            bcnt                        <= '0;
            phase                       <= 1'b0;
        end else if (mode_rise) begin
            // MODE wins over a coincident INC; timers restart in the new state
            state                       <= state_nxt;
            {SEL_HOUR, SEL_MIN, SEL_SEC} <= sel_enc(state_nxt);
            ENABLE                      <= 1'b0;
            INC_MODE                    <= 1'b0;
            BLINK                       <= 1'b0;
            presc                       <= '0;
            bcnt                        <= '0;
            phase                       <= 1'b0;
        end else if (state == RUN) begin
            INC_MODE <= 1'b0;
            BLINK    <= 1'b0;
            if (presc == TICK_LAST) begin
                presc  <= '0;
                ENABLE <= 1'b1;
            end else begin
                presc  <= presc + 1'b1;
                ENABLE <= 1'b0;
            end
        end else begin
            ENABLE   <= 1'b0;
            INC_MODE <= inc_rise;
            // an increment forces the field visible for its pulse cycle
            if (bcnt == BLINK_LAST) begin
                bcnt  <= '0;
                phase <= ~phase;
                BLINK <= inc_rise | ~phase;
            end else begin
                bcnt  <= bcnt + 1'b1;
                BLINK <= inc_rise | phase;
            end
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a cycle-level reference model.

module tb_clock_set_ctrl;
    localparam int TD = 10;
    localparam int DC = 4;
    localparam int BD = 3;

    logic       CLK, RESET_N, BTN_MODE, BTN_INC;
    logic       ENABLE, INC_MODE, BLINK;
    logic [1:0] SEL_SEC, SEL_MIN, SEL_HOUR, MODE_STATE;

    clock_set_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DC), .BLINK_DIV(BD)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .BTN_MODE   (BTN_MODE),
        .BTN_INC    (BTN_INC),
        .ENABLE     (ENABLE),
        .SEL_SEC    (SEL_SEC),
        .SEL_MIN    (SEL_MIN),
        .SEL_HOUR   (SEL_HOUR),
        .INC_MODE   (INC_MODE),
        .MODE_STATE (MODE_STATE),
        .BLINK      (BLINK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // {SEL_HOUR, SEL_MIN, SEL_SEC} required in each mode
    function automatic logic [5:0] sel_of(input int s);
        case (s)
            0:       sel_of = 6'b01_01_01;
            1:       sel_of = 6'b10_00_00;
            2:       sel_of = 6'b00_10_00;
            default: sel_of = 6'b00_00_10;
        endcase
    endfunction

    // Reference model: a button level is accepted once the last DC synchronized
    // samples (raw delayed two edges) all disagree with it; the action lands two
    // edges later. Timers are expressed as edges elapsed since the last mode change.
    bit hist [2][DC+2];
    bit acc  [2];
    bit p0   [2];
    bit p1   [2];
    int m_state, since;
    bit m_en, m_inc, m_blink, m_valid;

    task automatic model_step();
        bit fire [2];
        bit diff;
        if (!RESET_N) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DC + 2; i++) hist[b][i] = 1'b0;
                acc[b] = 1'b0; p0[b] = 1'b0; p1[b] = 1'b0;
            end
            m_state = 0; since = 0;
            m_en = 0; m_inc = 0; m_blink = 0;
            m_valid = 1;
        end else begin
            for (int b = 0; b < 2; b++) begin
                fire[b] = p1[b];
                p1[b]   = p0[b];
                for (int i = DC + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = (b == 0) ? BTN_MODE : BTN_INC;
                diff = 1'b1;
                for (int i = 2; i < DC + 2; i++) if (hist[b][i] == acc[b]) diff = 1'b0;
                p0[b] = 1'b0;
                if (diff) begin
                    acc[b] = ~acc[b];
                    p0[b]  = acc[b];
                end
            end
            if (fire[0]) begin
                m_state = (m_state + 1) % 4;
                since = 0; m_en = 0; m_inc = 0; m_blink = 0;
            end else begin
                since++;
                if (m_state == 0) begin
                    m_en = (since % TD) == 0;
                    m_inc = 0; m_blink = 0;
                end else begin
                    m_en = 0;
                    m_inc = fire[1];
                    m_blink = m_inc | (((since / BD) % 2) == 1);
                end
            end
        end
    endtask

    initial m_valid = 0;
    always @(posedge CLK) model_step();

    always @(negedge CLK) begin
        if (m_valid)
            chk("model_cycle",
                {MODE_STATE, SEL_HOUR, SEL_MIN, SEL_SEC, ENABLE, INC_MODE, BLINK},
                {m_state[1:0], sel_of(m_state), m_en, m_inc, m_blink});
    end

    // Clean 10-edge MODE press; the state must change exactly on the 8th edge (index 7).
    task automatic mode_press(input int exp_state);
        int prev;
        int en_bad;
        prev = (exp_state + 3) % 4;
        en_bad = 0;
        BTN_MODE = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (k == 6) chk("mode_before", MODE_STATE, prev);
            if (k == 7) begin
                chk("mode_after", MODE_STATE, exp_state);
                chk("sel_after", {SEL_HOUR, SEL_MIN, SEL_SEC}, sel_of(exp_state));
            end
            if (exp_state == 0 && k >= 8 && k <= 16 && ENABLE) en_bad++;
            if (exp_state == 0 && k == 17) chk("first_enable", ENABLE, 1);
            if (k == 9) BTN_MODE = 1'b0;
        end
        if (exp_state == 0) chk("enable_gap", en_bad, 0);
    endtask

    task automatic inc_press(input int exp_pulses);
        int cnt;
        cnt = 0;
        BTN_INC = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (INC_MODE) cnt++;
            if (exp_pulses != 0 && k == 7) chk("inc_pulse_blink", {INC_MODE, BLINK}, 2'b11);
            if (k == 9) BTN_INC = 1'b0;
        end
        chk("inc_count", cnt, exp_pulses);
    endtask

    initial begin
        int cnt;
        RESET_N = 1'b0; BTN_MODE = 1'b1; BTN_INC = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_outputs",
            {MODE_STATE, SEL_HOUR, SEL_MIN, SEL_SEC, ENABLE, INC_MODE, BLINK},
            {2'd0, 6'b01_01_01, 3'b000});
        RESET_N = 1'b1; BTN_MODE = 1'b0; BTN_INC = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            chk("run_enable", ENABLE, (i % 10) == 0);
        end

        // bounce: 3 high, 1 low, 2 high -- never DC consecutive samples
        BTN_MODE = 1'b1; repeat (3) @(negedge CLK);
        BTN_MODE = 1'b0; @(negedge CLK);
        BTN_MODE = 1'b1; repeat (2) @(negedge CLK);
        BTN_MODE = 1'b0; repeat (12) @(negedge CLK);
        chk("bounce_state", MODE_STATE, 0);

        mode_press(1);
        mode_press(2);
        mode_press(3);
        mode_press(0);

        mode_press(1);
        mode_press(2);
        inc_press(1);
        inc_press(1);
        inc_press(1);
        mode_press(3);
        mode_press(0);
        inc_press(0);

        // collision in SET_HOUR
        mode_press(1);
        cnt = 0;
        BTN_MODE = 1'b1; BTN_INC = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (INC_MODE) cnt++;
            if (k == 7) chk("collision_state", MODE_STATE, 2);
            if (k == 9) begin BTN_MODE = 1'b0; BTN_INC = 1'b0; end
        end
        chk("collision_inc", cnt, 0);

        // reset while INC is mid-debounce in SET_SEC
        mode_press(3);
        BTN_INC = 1'b1;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        chk("midreset_outputs",
            {MODE_STATE, SEL_HOUR, SEL_MIN, SEL_SEC, INC_MODE, BLINK},
            {2'd0, 6'b01_01_01, 2'b00});
        RESET_N = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (INC_MODE) cnt++;
        end
        chk("held_inc_after_reset", cnt, 0);
        chk("state_after_reset", MODE_STATE, 0);
        BTN_INC = 1'b0;
        repeat (10) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
